fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer for the async FIFO, in the rclk domain. It pops DSIZE-bit words
//  through the rinc/rempty/rdata interface and packs PACK consecutive words into one
//  wide beat. Each beat goes out on a valid/ready stream with byte-lane keep.
//  A flush input emits a partially filled beat. Sustains 1 word/cycle with no bubble
//  on beat hand-off.
// PARAMETERS
//  DSIZE  8   FIFO word width; must match FIFO DSIZE
//  PACK   4   words per output beat (>=1)
//  CNTW   16  width of word_cnt / beat_cnt statistics counters
// PORTS
//  rclk      in   1           read-domain clock; all logic on posedge
//  rrst      in   1           synchronous reset, active-high
//  rempty    in   1           FIFO empty flag (already synchronized to rclk)
//  rdata     in   DSIZE       FIFO head word; valid whenever rempty==0
//  rinc      out  1           pop strobe; head consumed on the rclk edge where rinc==1
//  flush     in   1           emit the partial beat (sampled in FILL only)
//  m_data    out  DSIZE*PACK  packed beat; lane i = bits [i*DSIZE +: DSIZE]
//  m_keep    out  PACK        lane-valid mask for m_data
//  m_valid   out  1           beat valid
//  m_ready   in   1           downstream accept
//  word_cnt  out  CNTW        total words popped (wraps)
//  beat_cnt  out  CNTW        total beats accepted (wraps)
// BEHAVIOUR
//  Reset (rrst==1 at posedge): state=FILL, idx=0, acc=0, m_valid=0, m_data=0,
//   m_keep=0, word_cnt=0, beat_cnt=0. rinc is forced 0 while rrst==1.
//   A reset mid-beat discards the partial and held beat; FIFO contents are untouched.
//  FIFO read is fall-through: rdata is combinational from the memory at raddr.
//   A pop is rinc=1, and the word is captured on the same edge. Zero read latency.
//  FSM:
//   FILL: rinc = !rempty.
//    - On pop: lane[idx] <= rdata, keep[idx] <= 1.
//      If idx==PACK-1: go to OUT, m_valid<=1, idx<=0. Otherwise idx<=idx+1.
//    - Flush: if flush==1 and (idx>0 or a pop occurs this cycle), go to OUT with the
//      lanes filled so far, including this cycle's pop. m_valid<=1, idx<=0.
//      Unfilled lanes read 0 with keep=0.
//    - flush with idx==0 and no pop: ignored.
//   OUT: m_valid=1. m_data/m_keep stay stable while m_ready==0; rinc=0 while m_ready==0.
//    - m_ready==1 completes the handshake and increments beat_cnt.
//    - Same cycle, rinc = !rempty. A popped word goes into lane0 of the fresh beat,
//      other lanes clear to 0/keep=0.
//    - Next state: OUT if PACK==1 and a pop occurred; else FILL with idx = (pop?1:0).
//      m_valid follows the next state.
//    - flush in OUT is ignored (not latched).
//  Lane order: first-popped word in lane0 (LSBs). A full beat has m_keep = all ones.
//  word_cnt increments on every rinc; beat_cnt increments on every m_valid&&m_ready.
//   Both wrap modulo 2^CNTW.
//  Never pops when rempty==1. No word is dropped or duplicated.
//  Throughput: PACK words per PACK cycles when the FIFO stays non-empty and m_ready=1.
// TESTING
//  1 PACK=4; FIFO preloaded 0x11..0x18, m_ready=1
//    -> beats 0x14131211, then 0x18171615, both keep=4'hF; word_cnt=8, beat_cnt=2;
//       rinc high 8 consecutive cycles.
//  2 Backpressure: m_ready=0 for 5 cycles once the first beat is valid
//    -> m_data holds 0x14131211; rinc=0 throughout; resumes with no loss.
//  3 Push 0xA1,0xA2, then flush=1 for 1 cycle
//    -> beat 0x0000A2A1, keep=4'b0011; flush on an empty accumulator produces no beat.
//  4 Flush in the same cycle as the 3rd pop (0xC3)
//    -> beat 0x00C3C2C1, keep=4'b0111.
//  5 Assert rrst mid-beat (2 lanes filled, FIFO non-empty)
//    -> outputs/counters 0 the next cycle; rinc=0 during reset;
//       packing restarts at lane0 with the next FIFO word.
//  6 PACK=1, CNTW=4; stream 20 words with m_ready=1
//    -> one beat per cycle with no bubble; word_cnt wraps 15->0 and reads 4 at the end.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the async FIFO: pops DSIZE-bit words from a fall-through
// read port and packs PACK of them into one valid/ready beat with byte-lane keep.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int CNTW  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNTW-1:0]       word_cnt,
    output logic [CNTW-1:0]       beat_cnt
);

    localparam int              IDXW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(PACK - 1);

    typedef enum logic [0:0] {
        FILL,
        OUT
    } state_t;

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [DSIZE*PACK-1:0] data_q;
    logic [PACK-1:0]       keep_q;
    logic                  valid_q;
    logic [CNTW-1:0]       word_cnt_q;
    logic [CNTW-1:0]       beat_cnt_q;

    logic pop;
    logic close_beat;

    // The pop decision must be combinational: the head word is captured on the same edge.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        pop        = 1'b0;
        close_beat = 1'b0;
        if (!rrst) begin
            case (state_q)
                FILL: begin
                    pop        = !rempty;
                    close_beat = (pop && idx_q == LAST) || (flush && (idx_q != '0 || pop));
                end
                OUT:     pop = m_ready && !rempty;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rrst) begin
            state_q    <= FILL;
            idx_q      <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (pop) begin
                word_cnt_q <= word_cnt_q + CNTW'(1);
            end
            case (state_q)
                FILL: begin
                    if (pop) begin
                        data_q[idx_q*DSIZE +: DSIZE] <= rdata;
                        keep_q[idx_q]                <= 1'b1;
                    end
                    if (close_beat) begin
                        state_q <= OUT;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                    end else if (pop) begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        beat_cnt_q <= beat_cnt_q + CNTW'(1);
                        // Fresh beat: lane0 takes this cycle's pop, later assignments win.
                        data_q <= '0;
                        keep_q <= '0;
                        if (pop) begin
                            data_q[DSIZE-1:0] <= rdata;
                            keep_q[0]         <= 1'b1;
                        end
                        if (PACK == 1 && pop) begin
                            state_q <= OUT;
                            valid_q <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            state_q <= FILL;
                            valid_q <= 1'b0;
                            idx_q   <= pop ? IDXW'(1) : '0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign rinc     = pop;
    assign m_data   = data_q;
    assign m_keep   = keep_q;
    assign m_valid  = valid_q;
    assign word_cnt = word_cnt_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO and word-list packing model drive two
// instances (PACK=4/CNTW=16 and PACK=1/CNTW=4), one active at a time.
module tb_fifo_rd_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rrst0 = 1'b1, rempty0 = 1'b1, flush0 = 1'b0, ready0 = 1'b0;
    logic [7:0]  rdata0 = 8'h00;
    logic        rinc0, valid0;
    logic [31:0] data0;
    logic [3:0]  keep0;
    logic [15:0] wcnt0, bcnt0;

    logic        rrst1 = 1'b1, rempty1 = 1'b1, flush1 = 1'b0, ready1 = 1'b0;
    logic [7:0]  rdata1 = 8'h00;
    logic        rinc1, valid1;
    logic [7:0]  data1;
    logic        keep1;
    logic [3:0]  wcnt1, bcnt1;

    fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(16)) dut (
        .rclk(clk), .rrst(rrst0), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0),
        .flush(flush0), .m_data(data0), .m_keep(keep0), .m_valid(valid0),
        .m_ready(ready0), .word_cnt(wcnt0), .beat_cnt(bcnt0)
    );

    fifo_rd_packer #(.DSIZE(8), .PACK(1), .CNTW(4)) dut1 (
        .rclk(clk), .rrst(rrst1), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
        .flush(flush1), .m_data(data1), .m_keep(keep1), .m_valid(valid1),
        .m_ready(ready1), .word_cnt(wcnt1), .beat_cnt(bcnt1)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic sel     = 1'b0;
    int   pk      = 4;
    int   cw      = 16;

    logic [7:0]  fifo[$];
    logic [7:0]  part[$];
    bit          has_beat;
    logic [31:0] bdata;
    logic [3:0]  bkeep;
    int          wcnt, bcnt;
    logic [31:0] log_data[$];
    logic [3:0]  log_keep[$];

    logic        obs_rinc, obs_valid;
    logic [31:0] obs_data;
    logic [3:0]  obs_keep;
    logic [15:0] obs_w, obs_b;

    always_comb begin
        if (sel) begin
            obs_rinc  = rinc1;
            obs_valid = valid1;
            obs_data  = {24'h0, data1};
            obs_keep  = {3'b0, keep1};
            obs_w     = {12'h0, wcnt1};
            obs_b     = {12'h0, bcnt1};
        end else begin
            obs_rinc  = rinc0;
            obs_valid = valid0;
            obs_data  = data0;
            obs_keep  = keep0;
            obs_w     = wcnt0;
            obs_b     = bcnt0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict with the word-list model, check around the edge.
    task automatic cycle(input bit rst, input bit fl, input bit rdy);
        bit          empty, exp_rinc, was_out, popped;
        logic [7:0]  w;
        logic [31:0] mask;
        empty = (fifo.size() == 0);
        w     = empty ? 8'h00 : fifo[0];
        if (sel) begin
            rrst1 = rst; flush1 = fl; ready1 = rdy; rempty1 = empty; rdata1 = w;
            rrst0 = 1'b1; flush0 = 1'b0; ready0 = 1'b0; rempty0 = 1'b1; rdata0 = 8'h00;
        end else begin
            rrst0 = rst; flush0 = fl; ready0 = rdy; rempty0 = empty; rdata0 = w;
            rrst1 = 1'b1; flush1 = 1'b0; ready1 = 1'b0; rempty1 = 1'b1; rdata1 = 8'h00;
        end
        #3;
        was_out = has_beat;
        if (rst) begin
            exp_rinc = 1'b0;
            part.delete();
            has_beat = 1'b0;
            bdata    = '0;
            bkeep    = '0;
            wcnt     = 0;
            bcnt     = 0;
        end else begin
            exp_rinc = was_out ? (rdy && !empty) : !empty;
            if (was_out && rdy) begin
                bcnt++;
                has_beat = 1'b0;
            end
            if (exp_rinc) begin
                part.push_back(w);
                wcnt++;
            end
            if (!has_beat && (part.size() == pk || (!was_out && fl && part.size() > 0))) begin
                bdata = '0;
                bkeep = '0;
                for (int i = 0; i < part.size(); i++) begin
                    bdata = bdata | (32'(part[i]) << (8 * i));
                    bkeep = bkeep | 4'(1 << i);
                end
                part.delete();
                has_beat = 1'b1;
            end
        end
        check("rinc", obs_rinc, exp_rinc);
        popped = obs_rinc;
        if (obs_valid && rdy && !rst) begin
            log_data.push_back(obs_data);
            log_keep.push_back(obs_keep);
        end
        @(posedge clk);
        #1;
        if (popped && fifo.size() > 0) void'(fifo.pop_front());
        mask = (32'd1 << cw) - 32'd1;
        check("m_valid", obs_valid, has_beat);
        if (has_beat || rst) begin
            check("m_data", obs_data, bdata);
            check("m_keep", obs_keep, bkeep);
        end
        check("word_cnt", obs_w, wcnt & mask);
        check("beat_cnt", obs_b, bcnt & mask);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_keep.delete();
    endtask

    task automatic expect_beat(input string tag, input int i, input logic [31:0] d,
                               input logic [3:0] k);
        check({tag, "_count"}, log_data.size() > i, 1'b1);
        if (log_data.size() > i) begin
            check({tag, "_data"}, log_data[i], d);
            check({tag, "_keep"}, log_keep[i], k);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle(1, 0, 0);
        cycle(1, 0, 0);

        // Preloaded 0x11..0x18 streams out as two full beats.
        clear_log();
        for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h11 + i));
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        expect_beat("t1_b0", 0, 32'h14131211, 4'hF);
        expect_beat("t1_b1", 1, 32'h18171615, 4'hF);
        check("t1_word_cnt", obs_w, 32'd8);
        check("t1_beat_cnt", obs_b, 32'd2);

        // Backpressure for 5 cycles once the first beat is valid.
        clear_log();
        for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h21 + i));
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1);
        expect_beat("t2_b0", 0, 32'h24232221, 4'hF);
        expect_beat("t2_b1", 1, 32'h28272625, 4'hF);

        // Flush a two-word partial, then flush on an empty accumulator.
        clear_log();
        fifo.push_back(8'hA1);
        fifo.push_back(8'hA2);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        expect_beat("t3_b0", 0, 32'h0000A2A1, 4'b0011);
        check("t3_no_extra_beat", log_data.size(), 32'd1);

        // Flush in the same cycle as the third pop.
        clear_log();
        fifo.push_back(8'hC1);
        fifo.push_back(8'hC2);
        fifo.push_back(8'hC3);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        expect_beat("t4_b0", 0, 32'h00C3C2C1, 4'b0111);

        // Reset mid-beat with the FIFO non-empty: packing restarts at the next word.
        clear_log();
        for (int i = 0; i < 6; i++) fifo.push_back(8'(8'hD1 + i));
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        expect_beat("t5_b0", 0, 32'hD6D5D4D3, 4'hF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0 && fifo.size() < 16) fifo.push_back(8'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0);
        end

        // PACK=1, CNTW=4 instance: one beat per cycle, word_cnt wraps.
        sel = 1'b1;
        pk  = 1;
        cw  = 4;
        fifo.delete();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        clear_log();
        for (int i = 0; i < 20; i++) fifo.push_back(8'(8'h40 + i));
        for (int i = 0; i < 21; i++) cycle(0, 0, 1);
        check("t6_beats", log_data.size(), 32'd20);
        expect_beat("t6_first", 0, 32'h40, 4'h1);
        expect_beat("t6_last", 19, 32'h53, 4'h1);
        check("t6_word_cnt", obs_w, 32'd4);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) != 0 && fifo.size() < 16) fifo.push_back(8'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
